level_sequencer: RTL and testbench
==================================

Name: level_sequencer

Overview:
Game controller that sequences the level answer memory for the guessing game. It fetches the answer for the current level from a synchronous-read ROM/BRAM and compares it against submitted guesses. It also tracks attempts, lives and score, and drives the status LEDs. It sits between the button debouncers and switch inputs on one side and the level memory on the other, and replaces the ad-hoc compare/advance logic in the top level.

Parameters:
NUM_LEVELS, 10, number of levels (ROM depth); addresses 0..NUM_LEVELS-1
DATA_W, 4, guess/answer width
MAX_TRIES, 3, wrong guesses allowed per level before game over
SCORE_W, 8, score register width (saturating)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
submit_pulse  input  1  one-cycle pulse from debouncer: evaluate guess
next_pulse  input  1  one-cycle pulse from debouncer: advance/skip/restart
data  input  DATA_W  guess switches, sampled on submit_pulse
rom_addr  output  $clog2(NUM_LEVELS)  level memory address
rom_data  input  DATA_W  level memory read data, valid 1 cycle after rom_addr
status  output  3  LED status code
level  output  $clog2(NUM_LEVELS)  current level index
tries_left  output  $clog2(MAX_TRIES+1)  remaining wrong guesses
score  output  SCORE_W  accumulated score
busy  output  1  high while fetching; pulses ignored

Behaviour:
- Reset (async, active-high): state=FETCH, level=0, rom_addr=0, tries_left=MAX_TRIES, score=0, status=000, busy=1.
- Status codes: 000 = waiting for guess, 001 = wrong, 010 = correct, 011 = game over, 100 = win.
- States: FETCH -> CAPTURE -> WAIT -> {CORRECT, WRONG, LOST, WON}.
- FETCH: rom_addr=level. Next cycle goes to CAPTURE.
- CAPTURE: answer register <= rom_data. Go to WAIT, busy=0, status=000. Latency is 2 cycles from entering FETCH to WAIT.
- WAIT/WRONG, submit_pulse: guess=data is compared to the answer. Status updates on the cycle after the pulse.
  - Equal: goto CORRECT, status=010, score += tries_left (saturating at 2^SCORE_W-1).
  - Not equal, tries_left>1: tries_left--, goto WRONG, status=001.
  - Not equal, tries_left==1: tries_left=0, goto LOST, status=011.
- CORRECT, next_pulse:
  - level < NUM_LEVELS-1: level++, tries_left=MAX_TRIES, goto FETCH.
  - level == NUM_LEVELS-1: goto WON, status=100.
- WAIT/WRONG, next_pulse (skip): level advances as above with no score change and tries reset. On the last level, a skip wraps level to 0 (not WON).
- LOST/WON: submit ignored. next_pulse restarts: level=0, score=0, tries_left=MAX_TRIES, goto FETCH.
- Simultaneous submit_pulse and next_pulse: submit wins and next is dropped.
- Pulses during FETCH/CAPTURE (busy=1) are dropped, not queued.
- CORRECT: further submits are ignored; status holds 010.
- Reset mid-fetch or mid-game returns immediately to the reset state. No residual answer or score is retained.
- All outputs are registered.

Optional Feature:
LEVEL_HINT_EN:
- Defined: a wrong guess reports direction instead of 001. Status=101 when guess < answer, 110 when guess > answer (unsigned compare). LOST still reports 011.
- Undefined: all wrong guesses report 001. Codes 101/110 never appear, and the magnitude comparator is not synthesised.

Decomposition:
- Shared package game_pkg:
  - state enum (FETCH, CAPTURE, WAIT, CORRECT, WRONG, LOST, WON)
  - status code constants ST_WAIT, ST_WRONG, ST_CORRECT, ST_LOST, ST_WIN, ST_LOW, ST_HIGH
  - status width constant
- No sub-module needed. The FSM, comparator and saturating score adder are small enough to stay inline; the level memory remains external.

Test Plan:
- Bench ROM model: 14,11,8,5,2,15,12,9,6,3.
- Reset release, then wait 2 cycles -> busy=0, status=000, level=0, tries_left=3, score=0.
- Submit data=14 at level 0 -> next cycle status=010, score=3. Then next_pulse -> level=1, busy for 2 cycles, status=000.
- Level 1, submit 7, 7, 7 -> tries_left 2, 1, 0. Status 001, 001, 011 (with LEVEL_HINT_EN: 101, 101, 011). Then next_pulse -> level=0, score=0.
- submit_pulse and next_pulse in the same cycle with data=correct -> status=010, level unchanged. A pulse during busy is dropped.
- Play all 10 levels correctly on the first try -> after the last next_pulse, status=100, score=30. With SCORE_W=4, score saturates at 15.
- Assert reset during CAPTURE of level 5 -> outputs immediately return to reset values. After 2 cycles, rom_addr=0 and the answer is 14.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state and status encodings for the guessing-game sequencer
//
// Purpose: state enumeration and LED status codes used by level_sequencer.
// Ports: none (package).

package game_pkg;

  localparam int STATUS_W = 3;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    CAPTURE = 3'd1,
    WAIT    = 3'd2,
    CORRECT = 3'd3,
    WRONG   = 3'd4,
    LOST    = 3'd5,
    WON     = 3'd6
  } state_t;

  localparam logic [STATUS_W-1:0] ST_WAIT    = 3'b000;
  localparam logic [STATUS_W-1:0] ST_WRONG   = 3'b001;
  localparam logic [STATUS_W-1:0] ST_CORRECT = 3'b010;
  localparam logic [STATUS_W-1:0] ST_LOST    = 3'b011;
  localparam logic [STATUS_W-1:0] ST_WIN     = 3'b100;
  localparam logic [STATUS_W-1:0] ST_LOW     = 3'b101;
  localparam logic [STATUS_W-1:0] ST_HIGH    = 3'b110;

endpackage

// File: rtl/level_sequencer.sv
// rtl/level_sequencer.sv - level fetch, guess compare, tries/lives/score tracking
//
// Purpose: fetches the answer for the current level from an external
// synchronous-read memory, evaluates submitted guesses, and tracks tries,
// level and a saturating score. Optional macro LEVEL_HINT_EN makes wrong
// guesses report low/high direction instead of a plain "wrong" code.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   submit_pulse one-cycle pulse: evaluate data against the answer
//   next_pulse   one-cycle pulse: advance / skip / restart
//   data         guess switches
//   rom_addr     level memory address (read data returns one cycle later)
//   rom_data     level memory read data
//   status       LED status code
//   level        current level index
//   tries_left   remaining wrong guesses on this level
//   score        saturating accumulated score
//   busy         high while the answer is being fetched; pulses dropped

module level_sequencer
  import game_pkg::*;
#(
  parameter int NUM_LEVELS = 10,
  parameter int DATA_W     = 4,
  parameter int MAX_TRIES  = 3,
  parameter int SCORE_W    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             submit_pulse,
  input  logic                             next_pulse,
  input  logic [DATA_W-1:0]                data,
  output logic [$clog2(NUM_LEVELS)-1:0]    rom_addr,
  input  logic [DATA_W-1:0]                rom_data,
  output logic [STATUS_W-1:0]              status,
  output logic [$clog2(NUM_LEVELS)-1:0]    level,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic [SCORE_W-1:0]               score,
  output logic                             busy
);

  localparam int LW = $clog2(NUM_LEVELS);
  localparam int TW = $clog2(MAX_TRIES+1);

  localparam logic [LW-1:0] LAST_LEVEL = LW'(NUM_LEVELS-1);
  localparam logic [TW-1:0] FULL_TRIES = TW'(MAX_TRIES);
  localparam logic [TW-1:0] ONE_TRY    = TW'(1);

  state_t                r_state, w_state;
  logic [LW-1:0]         r_level, w_level;
  logic [TW-1:0]         r_tries, w_tries;
  logic [SCORE_W-1:0]    r_score, w_score;
  logic [STATUS_W-1:0]   r_status, w_status;
  logic [DATA_W-1:0]     r_answer, w_answer;
  logic                  r_busy, w_busy;

  logic [SCORE_W:0]      w_sum;
  logic [SCORE_W-1:0]    w_score_sat;
  logic [STATUS_W-1:0]   w_wrong_code;
  logic [LW-1:0]         w_level_inc;

  // One extra bit catches the carry so the score clamps instead of wrapping.
  assign w_sum       = {1'b0, r_score} + (SCORE_W+1)'(r_tries);
  assign w_score_sat = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];

  // Skips wrap on the last level; CORRECT handles the last level separately.
  assign w_level_inc = (r_level == LAST_LEVEL) ? '0 : r_level + 1'b1;

`ifdef LEVEL_HINT_EN
  assign w_wrong_code = (data < r_answer) ? ST_LOW : ST_HIGH;
`else
  assign w_wrong_code = ST_WRONG;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= FETCH;
      r_level  <= '0;
      r_tries  <= FULL_TRIES;
      r_score  <= '0;
      r_status <= ST_WAIT;
      r_answer <= '0;
      r_busy   <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_level  <= w_level;
      r_tries  <= w_tries;
      r_score  <= w_score;
      r_status <= w_status;
      r_answer <= w_answer;
      r_busy   <= w_busy;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_level  = r_level;
    w_tries  = r_tries;
    w_score  = r_score;
    w_status = r_status;
    w_answer = r_answer;

    case (r_state)
      // Address is already driven from r_level; the memory returns data
      // during CAPTURE.
      FETCH: w_state = CAPTURE;

      CAPTURE: begin
        w_answer = rom_data;
        w_state  = WAIT;
        w_status = ST_WAIT;
      end

      // Submit takes priority over a same-cycle next pulse.
      WAIT, WRONG: begin
        if (submit_pulse) begin
          if (data == r_answer) begin
            w_state  = CORRECT;
            w_status = ST_CORRECT;
            w_score  = w_score_sat;
          end else if (r_tries > ONE_TRY) begin
            w_state  = WRONG;
            w_status = w_wrong_code;
            w_tries  = r_tries - 1'b1;
          end else begin
            w_state  = LOST;
            w_status = ST_LOST;
            w_tries  = '0;
          end
        end else if (next_pulse) begin
          w_state  = FETCH;
          w_status = ST_WAIT;
          w_level  = w_level_inc;
          w_tries  = FULL_TRIES;
        end
      end

      CORRECT: begin
        if (next_pulse) begin
          if (r_level == LAST_LEVEL) begin
            w_state  = WON;
            w_status = ST_WIN;
          end else begin
            w_state  = FETCH;
            w_status = ST_WAIT;
            w_level  = w_level_inc;
            w_tries  = FULL_TRIES;
          end
        end
      end

      LOST, WON: begin
        if (next_pulse) begin
          w_state  = FETCH;
          w_status = ST_WAIT;
          w_level  = '0;
          w_score  = '0;
          w_tries  = FULL_TRIES;
        end
      end

      default: begin
        w_state  = FETCH;
        w_status = ST_WAIT;
        w_level  = '0;
        w_score  = '0;
        w_tries  = FULL_TRIES;
      end
    endcase

    w_busy = (w_state == FETCH) || (w_state == CAPTURE);
  end

  assign rom_addr   = r_level;
  assign level      = r_level;
  assign tries_left = r_tries;
  assign score      = r_score;
  assign status     = r_status;
  assign busy       = r_busy;

endmodule

// File: tb/tb_level_sequencer.sv
// tb/tb_level_sequencer.sv - directed self-checking bench for level_sequencer

module tb_level_sequencer;

`ifdef LEVEL_HINT_EN
  localparam logic [2:0] WL = 3'b101;
  localparam logic [2:0] WH = 3'b110;
`else
  localparam logic [2:0] WL = 3'b001;
  localparam logic [2:0] WH = 3'b001;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       submit_pulse;
  logic       next_pulse;
  logic [3:0] data;
  logic [3:0] rom_addr, rom_addr4;
  logic [3:0] rom_data, rom_data4;
  logic [2:0] status, status4;
  logic [3:0] level, level4;
  logic [1:0] tries_left, tries4;
  logic [7:0] score;
  logic [3:0] score4;
  logic       busy, busy4;

  logic [3:0] rom [10];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  level_sequencer dut (
    .clk(clk), .reset(reset), .submit_pulse(submit_pulse), .next_pulse(next_pulse),
    .data(data), .rom_addr(rom_addr), .rom_data(rom_data), .status(status),
    .level(level), .tries_left(tries_left), .score(score), .busy(busy)
  );

  level_sequencer #(.SCORE_W(4)) dut4 (
    .clk(clk), .reset(reset), .submit_pulse(submit_pulse), .next_pulse(next_pulse),
    .data(data), .rom_addr(rom_addr4), .rom_data(rom_data4), .status(status4),
    .level(level4), .tries_left(tries4), .score(score4), .busy(busy4)
  );

  always @(posedge clk) begin
    rom_data  <= (rom_addr  < 4'd10) ? rom[rom_addr]  : 4'd0;
    rom_data4 <= (rom_addr4 < 4'd10) ? rom[rom_addr4] : 4'd0;
  end

  typedef struct {
    logic       s;
    logic       n;
    logic [3:0] d;
    logic [2:0] st;
    int         lvl;
    int         tr;
    int         sc;
    logic       bz;
  } vec_t;

  vec_t vt [22];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called at posedge+1; drives inputs for one cycle and returns at the next posedge+1.
  task automatic step(input logic s, input logic n, input logic [3:0] d);
    submit_pulse = s;
    next_pulse   = n;
    data         = d;
    @(posedge clk);
    #1;
    submit_pulse = 1'b0;
    next_pulse   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic play_level(input int l);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, rom[l]);
    step(0, 1, 0);
  endtask

  initial begin
    rom[0] = 14; rom[1] = 11; rom[2] = 8; rom[3] = 5; rom[4] = 2;
    rom[5] = 15; rom[6] = 12; rom[7] = 9; rom[8] = 6; rom[9] = 3;

    vt[0]  = '{0, 0, 0,  3'b000, 0, 3, 0, 1};
    vt[1]  = '{0, 0, 0,  3'b000, 0, 3, 0, 0};
    vt[2]  = '{1, 0, 14, 3'b010, 0, 3, 3, 0};
    vt[3]  = '{1, 0, 0,  3'b010, 0, 3, 3, 0};
    vt[4]  = '{0, 1, 0,  3'b000, 1, 3, 3, 1};
    vt[5]  = '{1, 0, 11, 3'b000, 1, 3, 3, 1};
    vt[6]  = '{0, 0, 0,  3'b000, 1, 3, 3, 0};
    vt[7]  = '{1, 0, 7,  WL,     1, 2, 3, 0};
    vt[8]  = '{1, 0, 7,  WL,     1, 1, 3, 0};
    vt[9]  = '{1, 0, 7,  3'b011, 1, 0, 3, 0};
    vt[10] = '{1, 0, 11, 3'b011, 1, 0, 3, 0};
    vt[11] = '{0, 1, 0,  3'b000, 0, 3, 0, 1};
    vt[12] = '{0, 0, 0,  3'b000, 0, 3, 0, 1};
    vt[13] = '{0, 0, 0,  3'b000, 0, 3, 0, 0};
    vt[14] = '{1, 0, 15, WH,     0, 2, 0, 0};
    vt[15] = '{1, 1, 14, 3'b010, 0, 2, 2, 0};
    vt[16] = '{0, 1, 0,  3'b000, 1, 3, 2, 1};
    vt[17] = '{0, 0, 0,  3'b000, 1, 3, 2, 1};
    vt[18] = '{0, 0, 0,  3'b000, 1, 3, 2, 0};
    vt[19] = '{0, 1, 0,  3'b000, 2, 3, 2, 1};
    vt[20] = '{0, 0, 0,  3'b000, 2, 3, 2, 1};
    vt[21] = '{0, 0, 0,  3'b000, 2, 3, 2, 0};

    reset        = 1'b1;
    submit_pulse = 1'b0;
    next_pulse   = 1'b0;
    data         = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_status",   int'(status),     0);
    chk("rst_level",    int'(level),      0);
    chk("rst_rom_addr", int'(rom_addr),   0);
    chk("rst_tries",    int'(tries_left), 3);
    chk("rst_score",    int'(score),      0);
    chk("rst_busy",     int'(busy),       1);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      step(vt[i].s, vt[i].n, vt[i].d);
      chk($sformatf("v%0d_status", i), int'(status),     int'(vt[i].st));
      chk($sformatf("v%0d_level", i),  int'(level),      vt[i].lvl);
      chk($sformatf("v%0d_tries", i),  int'(tries_left), vt[i].tr);
      chk($sformatf("v%0d_score", i),  int'(score),      vt[i].sc);
      chk($sformatf("v%0d_busy", i),   int'(busy),       int'(vt[i].bz));
    end

    // Full game, first try every level: win, score 30, narrow score saturates.
    do_reset();
    for (int l = 0; l < 10; l++) play_level(l);
    chk("win_status",   int'(status),  4);
    chk("win_status4",  int'(status4), 4);
    chk("win_level",    int'(level),   9);
    chk("win_score",    int'(score),   30);
    chk("win_score4",   int'(score4),  15);
    step(1, 0, 3);
    chk("win_submit_ignored", int'(status), 4);
    step(0, 1, 0);
    chk("restart_level", int'(level), 0);
    chk("restart_score", int'(score), 0);
    chk("restart_busy",  int'(busy),  1);

    // Skip through every level; the skip from the last level wraps to 0.
    for (int l = 0; l < 10; l++) begin
      step(0, 0, 0);
      step(0, 0, 0);
      if (l == 9) chk("skip_reach_last", int'(level), 9);
      step(0, 1, 0);
    end
    chk("skip_wrap_level",  int'(level),  0);
    chk("skip_wrap_status", int'(status), 0);
    chk("skip_wrap_score",  int'(score),  0);

    // Reset asynchronously while level 5 is in CAPTURE.
    do_reset();
    for (int l = 0; l < 5; l++) play_level(l);
    step(0, 0, 0);
    chk("pre_rst_level", int'(level), 5);
    chk("pre_rst_busy",  int'(busy),  1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_level",  int'(level),      0);
    chk("async_rst_score",  int'(score),      0);
    chk("async_rst_tries",  int'(tries_left), 3);
    chk("async_rst_status", int'(status),     0);
    chk("async_rst_busy",   int'(busy),       1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("post_rst_rom_addr", int'(rom_addr), 0);
    chk("post_rst_busy",     int'(busy),     0);
    step(1, 0, 14);
    chk("post_rst_answer", int'(status), 2);
    chk("post_rst_score",  int'(score),  3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
